// File: rtl/irq_controller.sv
// irq_controller: memory-mapped priority interrupt controller with claim/EOI sequencing.
// Define IRQ_SYNC_EN to pass iSrc through a 2-flop synchronizer before edge detection.
module irq_controller #(
    parameter int          NUM_SRC   = 4,
    parameter logic [31:0] ADDR_BASE = 32'h4000_0040
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] iSrc,
    input  logic [31:0]        iAddr,
    input  logic               iWrite,
    input  logic               iRead,
    input  logic [31:0]        iWriteData,
    output logic [31:0]        oReadData,
    output logic               oSel,
    output logic               oInterrupt
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PENDING = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    localparam logic [2:0] OFF_PEND  = 3'd0;
    localparam logic [2:0] OFF_MASK  = 3'd1;
    localparam logic [2:0] OFF_ID    = 3'd2;
    localparam logic [2:0] OFF_CLAIM = 3'd3;
    localparam logic [2:0] OFF_EOI   = 3'd4;

    logic [NUM_SRC-1:0] src;
    logic [NUM_SRC-1:0] src_prev_q, src_prev_d;
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] clr;
    logic [NUM_SRC-1:0] pend_kept;
    logic [NUM_SRC-1:0] active;
    logic [1:0]         state_q, state_d;
    logic [4:0]         claimed_id_q, claimed_id_d;
    logic [4:0]         id;
    logic               id_valid;
    logic               claim_fire;
    logic [2:0]         off;
    logic               wr_en;
    logic               wr_pend;
    logic               wr_mask;
    logic               wr_claim;
    logic               wr_eoi;
    logic               unused_bits;

`ifdef IRQ_SYNC_EN
    logic [NUM_SRC-1:0] sync1_q, sync1_d;
    logic [NUM_SRC-1:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = iSrc;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign src = sync2_q;
`else
    assign src = iSrc;
`endif

    assign off      = iAddr[4:2];
    assign oSel     = (iAddr[31:5] == ADDR_BASE[31:5]);
    assign wr_en    = oSel & iWrite;
    assign wr_pend  = wr_en & (off == OFF_PEND);
    assign wr_mask  = wr_en & (off == OFF_MASK);
    assign wr_claim = wr_en & (off == OFF_CLAIM);
    assign wr_eoi   = wr_en & (off == OFF_EOI);

    assign unused_bits = ^{iAddr[1:0], iWriteData};

    assign active   = pend_q & mask_q;
    assign id_valid = |active;

    // Downward scan so the lowest set index wins.
    always_comb begin
        id = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (active[i]) begin
                id = 5'(i);
            end
        end
    end

    always_comb begin
        src_prev_d   = src;
        rise         = src & ~src_prev_q;
        mask_d       = wr_mask ? iWriteData[NUM_SRC-1:0] : mask_q;
        claim_fire   = wr_claim & (state_q == ST_PENDING);
        clr          = wr_pend ? iWriteData[NUM_SRC-1:0] : '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (claim_fire && (id == 5'(i))) begin
                clr[i] = 1'b1;
            end
        end
        pend_kept    = pend_q & ~clr;
        pend_d       = pend_kept | rise;
        claimed_id_d = claim_fire ? id : claimed_id_q;
    end

    // IDLE ignores this cycle's rise so a new edge costs one extra cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|(pend_kept & mask_d)) begin
                    state_d = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (claim_fire) begin
                    state_d = ST_SERVICE;
                end else if (~|(pend_d & mask_d)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (wr_eoi) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            src_prev_q   <= '0;
            pend_q       <= '0;
            mask_q       <= '0;
            state_q      <= ST_IDLE;
            claimed_id_q <= '0;
        end else begin
            src_prev_q   <= src_prev_d;
            pend_q       <= pend_d;
            mask_q       <= mask_d;
            state_q      <= state_d;
            claimed_id_q <= claimed_id_d;
        end
    end

    assign oInterrupt = (state_q == ST_PENDING);

    always_comb begin
        oReadData = '0;
        if (oSel && iRead) begin
            case (off)
                OFF_PEND:  oReadData = 32'(pend_q);
                OFF_MASK:  oReadData = 32'(mask_q);
                OFF_ID:    oReadData = {id_valid, 26'b0, id};
                OFF_CLAIM: oReadData = {(state_q == ST_SERVICE), 26'b0, claimed_id_q};
                default:   oReadData = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed scenarios plus randomized traffic checked
// every cycle against a rule-level model of the interrupt controller.
module tb_irq_controller;

    localparam int          N    = 4;
    localparam logic [31:0] BASE = 32'h4000_0040;
`ifdef IRQ_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [N-1:0] iSrc = '1;
    logic [31:0]  iAddr = '0;
    logic         iWrite = 1'b0;
    logic         iRead = 1'b0;
    logic [31:0]  iWriteData = '0;
    logic [31:0]  oReadData;
    logic         oSel;
    logic         oInterrupt;

    irq_controller #(.NUM_SRC(N), .ADDR_BASE(BASE)) dut (
        .clk(clk),
        .reset(reset),
        .iSrc(iSrc),
        .iAddr(iAddr),
        .iWrite(iWrite),
        .iRead(iRead),
        .iWriteData(iWriteData),
        .oReadData(oReadData),
        .oSel(oSel),
        .oInterrupt(oInterrupt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    // Model: pending/mask sets, request and in-service flags, claimed id.
    int m_pend = 0, m_mask = 0, m_prev = 0, m_s1 = 0, m_s2 = 0, m_cid = 0;
    bit m_req = 0, m_serv = 0;

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic int lowest(int v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic bit m_sel();
        return iAddr[31:5] == BASE[31:5];
    endfunction

    function automatic logic [31:0] exp_rd();
        int act;
        act = m_pend & m_mask;
        if (!(m_sel() && iRead)) return 32'h0;
        case (iAddr[4:2])
            3'd0: return 32'(m_pend);
            3'd1: return 32'(m_mask);
            3'd2: return (act != 0) ? {1'b1, 26'b0, 5'(lowest(act))} : 32'h0;
            3'd3: return {m_serv, 26'b0, 5'(m_cid)};
            default: return 32'h0;
        endcase
    endfunction

    function automatic void model_step();
        int src, rise, off, clr, nmask, kept, npend, all;
        bit wr, claim, was_idle;
        all = (1 << N) - 1;
        if (!reset) begin
            m_pend = 0; m_mask = 0; m_prev = 0; m_s1 = 0; m_s2 = 0;
            m_cid = 0; m_req = 0; m_serv = 0;
            return;
        end
        wr = m_sel() && iWrite;
        off = int'(iAddr[4:2]);
        if (LAT != 0) src = m_s2;
        else src = int'(iSrc);
        m_s2 = m_s1;
        m_s1 = int'(iSrc);
        rise = src & ~m_prev & all;
        m_prev = src;
        nmask = (wr && off == 1) ? int'(iWriteData) & all : m_mask;
        clr = (wr && off == 0) ? int'(iWriteData) & all : 0;
        was_idle = !m_req && !m_serv;
        claim = wr && off == 3 && m_req;
        if (claim) begin
            m_cid = lowest(m_pend & m_mask);
            clr = clr | (1 << m_cid);
            m_serv = 1;
            m_req = 0;
        end else if (wr && off == 4 && m_serv) begin
            m_serv = 0;
        end
        kept = m_pend & ~clr;
        npend = kept | rise;
        if (was_idle) m_req = (kept & nmask) != 0;
        else if (m_req) m_req = (npend & nmask) != 0;
        m_pend = npend;
        m_mask = nmask;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            #2;
            chk("cmp_sel", 32'(oSel), 32'(m_sel()));
            chk("cmp_irq", 32'(oInterrupt), 32'(m_req));
            chk("cmp_rdata", oReadData, exp_rd());
        end
    end

    task automatic cyc(logic w, logic r, logic [7:0] off, logic [31:0] d);
        @(negedge clk);
        iWrite = w;
        iRead = r;
        iAddr = BASE + 32'(off);
        iWriteData = d;
    endtask

    task automatic wr(logic [7:0] off, logic [31:0] d);
        cyc(1'b1, 1'b0, off, d);
    endtask

    task automatic idle(int n);
        repeat (n) cyc(1'b0, 1'b0, 8'h00, 32'h0);
    endtask

    task automatic rd(logic [7:0] off, logic [31:0] exp, string nm);
        cyc(1'b0, 1'b1, off, 32'h0);
        #1;
        chk(nm, oReadData, exp);
    endtask

    task automatic irq(logic exp, string nm);
        #1;
        chk(nm, 32'(oInterrupt), 32'(exp));
    endtask

    initial begin
        // Reset with all sources high
        idle(2);
        irq(1'b0, "rst_irq");
        cyc(1'b0, 1'b1, 8'h00, 32'h0);
        reset = 1'b1;
        #1;
        chk("rst_pend", oReadData, 32'h0);
        rd(8'h04, 32'h0, "rst_mask");
        iSrc = '0;
        idle(LAT + 2);
        rd(8'h00, 32'hF, "rst_edge_pend");
        wr(8'h00, 32'hF);
        rd(8'h00, 32'h0, "w1c_all");

        // Basic
        wr(8'h04, 32'h4);
        idle(1);
        iSrc = 4'h4;
        idle(LAT);
        rd(8'h00, 32'h4, "basic_pend");
        irq(1'b0, "basic_irq_early");
        idle(1);
        irq(1'b1, "basic_irq");
        rd(8'h08, 32'h8000_0002, "basic_id");
        wr(8'h0C, 32'h0);
        idle(1);
        irq(1'b0, "claim_irq");
        rd(8'h00, 32'h0, "claim_pend");
        rd(8'h0C, 32'h8000_0002, "claim_rd");
        wr(8'h10, 32'h0);
        rd(8'h0C, 32'h0000_0002, "eoi_claim");
        irq(1'b0, "eoi_irq");
        iSrc = '0;

        // Priority
        wr(8'h04, 32'hF);
        iSrc = 4'hA;
        idle(LAT + 2);
        irq(1'b1, "prio_irq");
        rd(8'h08, 32'h8000_0001, "prio_id");
        wr(8'h0C, 32'h0);
        wr(8'h10, 32'h0);
        idle(1);
        irq(1'b0, "prio_gap");
        idle(1);
        irq(1'b1, "prio_re");
        rd(8'h08, 32'h8000_0003, "prio_id2");
        wr(8'h0C, 32'h0);
        wr(8'h10, 32'h0);
        iSrc = '0;
        idle(2);

        // Masking
        wr(8'h04, 32'h0);
        iSrc = 4'h1;
        idle(LAT + 2);
        rd(8'h00, 32'h1, "mask_pend");
        irq(1'b0, "mask_irq0");
        wr(8'h04, 32'h1);
        idle(1);
        irq(1'b1, "unmask_irq");
        wr(8'h04, 32'h0);
        idle(1);
        irq(1'b0, "remask_irq");
        wr(8'h00, 32'h1);
        iSrc = '0;

        // Collision: rise and W1C on the same bit
        idle(1);
        iSrc = 4'h2;
        idle(1);
        iSrc = 4'h0;
        idle(LAT + 2);
        if (LAT == 0) begin
            wr(8'h00, 32'h2);
            iSrc = 4'h2;
        end else begin
            idle(1);
            iSrc = 4'h2;
            idle(LAT - 1);
            wr(8'h00, 32'h2);
        end
        rd(8'h00, 32'h2, "collide_pend");
        wr(8'h10, 32'h0);
        idle(1);
        irq(1'b0, "eoi_idle_irq");
        rd(8'h0C, 32'h0000_0003, "eoi_idle_claim");
        wr(8'h04, 32'h2);
        idle(1);
        irq(1'b1, "c5_irq");
        wr(8'h0C, 32'h0);
        iSrc = 4'h0;
        idle(1);
        iSrc = 4'h2;
        idle(LAT + 1);
        wr(8'h0C, 32'h0);
        rd(8'h0C, 32'h8000_0001, "claim_in_serv");
        rd(8'h00, 32'h2, "claim_in_serv_pend");
        irq(1'b0, "serv_irq");
        wr(8'h10, 32'h0);
        idle(2);
        irq(1'b1, "eoi_repend");
        wr(8'h04, 32'h0);
        wr(8'h00, 32'hF);
        iSrc = '0;

        // Decode
        wr(8'h04, 32'h3);
        cyc(1'b0, 1'b1, 8'h20, 32'h0);
        #1;
        chk("dec_sel", 32'(oSel), 32'h0);
        chk("dec_rd", oReadData, 32'h0);
        wr(8'h14, 32'hFFFF_FFFF);
        rd(8'h04, 32'h3, "dec_mask");
        rd(8'h00, 32'h0, "dec_pend");
        rd(8'h14, 32'h0, "dec_rsv");
        wr(8'h04, 32'h0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            int op;
            logic [7:0] off;
            op = int'($urandom_range(0, 9));
            off = 8'($urandom_range(0, 7) * 4);
            if ($urandom_range(0, 15) == 0) off = off + 8'h20;
            cyc(op < 3, op >= 3 && op < 7, off, $urandom);
            if ($urandom_range(0, 3) == 0) iSrc = 4'($urandom);
            reset = ($urandom_range(0, 199) != 0);
        end
        reset = 1'b1;
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
